// File: rtl/spi_flash_init_seq.sv
// Power-up sequencer for the SPI flash: waits out power-up, sends Reset-Enable/Reset,
// then polls the status register until WIP clears (init_done) or polls run out (init_error).
module spi_flash_init_seq #(
    parameter int CLK_DIV        = 2,
    parameter int POWERUP_CYCLES = 1024,
    parameter int CS_HIGH_CYCLES = 4,
    parameter int RESET_CYCLES   = 2048,
    parameter int MAX_POLLS      = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init_mode,
    output logic init_done,
    output logic init_error,
    output logic spi_sck,
    output logic spi_cs_n,
    output logic spi_mosi,
    input  logic spi_miso
);
    localparam int WAIT_MAX_A = (POWERUP_CYCLES > RESET_CYCLES) ? POWERUP_CYCLES : RESET_CYCLES;
    localparam int WAIT_MAX   = (WAIT_MAX_A > CS_HIGH_CYCLES) ? WAIT_MAX_A : CS_HIGH_CYCLES;
    localparam int WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam int DIV_W      = $clog2(CLK_DIV + 1);
    localparam int POLL_W     = $clog2(MAX_POLLS + 1);

    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [3:0] {
        S_IDLE, S_POWERUP, S_CMD_RSTEN, S_GAP1, S_CMD_RST,
        S_RST_WAIT, S_POLL, S_POLL_GAP, S_DONE, S_ERROR
    } state_t;

    state_t              state, state_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_d;
    logic [DIV_W-1:0]    div_cnt, div_d;
    logic [5:0]          half_cnt, half_d, last_half;
    logic [15:0]         tx_sr, tx_d;
    logic [7:0]          rx_sr, rx_d;
    logic [POLL_W-1:0]   poll_cnt, poll_d, poll_inc;
    logic                start_frame, in_frame;
    logic [7:0]          start_op;
    logic                cs_n_d, sck_d, mosi_d;

    always_comb begin
        state_d     = state;
        wait_d      = wait_cnt;
        div_d       = div_cnt;
        half_d      = half_cnt;
        tx_d        = tx_sr;
        rx_d        = rx_sr;
        poll_d      = poll_cnt;
        start_frame = 1'b0;
        start_op    = OP_RDSR;
        in_frame    = 1'b0;
        cs_n_d      = 1'b1;
        sck_d       = 1'b0;
        mosi_d      = 1'b0;
        poll_inc    = (poll_cnt == POLL_W'(MAX_POLLS)) ? poll_cnt : poll_cnt + POLL_W'(1);
        last_half   = (state == S_POLL) ? 6'd32 : 6'd16;

        case (state)
            S_IDLE: begin
                if (init_mode) begin
                    state_d = S_POWERUP;
                    wait_d  = WAIT_W'(POWERUP_CYCLES - 1);
                end
            end
            S_POWERUP, S_GAP1, S_RST_WAIT, S_POLL_GAP: begin
                if (!init_mode) begin
                    state_d = S_IDLE;
                end else if (wait_cnt == '0) begin
                    start_frame = 1'b1;
                    case (state)
                        S_POWERUP: begin state_d = S_CMD_RSTEN; start_op = OP_RSTEN; end
                        S_GAP1:    begin state_d = S_CMD_RST;   start_op = OP_RST;   end
                        S_RST_WAIT: begin state_d = S_POLL; poll_d = '0; end
                        default:   state_d = S_POLL;
                    endcase
                end else begin
                    wait_d = wait_cnt - WAIT_W'(1);
                end
            end
            S_CMD_RSTEN, S_CMD_RST, S_POLL: begin
                in_frame = 1'b1;
                if (div_cnt != DIV_W'(CLK_DIV - 1)) begin
                    div_d = div_cnt + DIV_W'(1);
                end else if (half_cnt != last_half) begin
                    // Odd half-periods are SCK high: shift out on the fall, sample MISO on the rise.
                    div_d  = '0;
                    half_d = half_cnt + 6'd1;
                    if (!half_d[0])
                        tx_d = {tx_sr[14:0], 1'b0};
                    else if (half_cnt >= 6'd16)
                        rx_d = {rx_sr[6:0], spi_miso};
                end else begin
                    in_frame = 1'b0;
                    case (state)
                        S_CMD_RSTEN: begin
                            state_d = init_mode ? S_GAP1 : S_IDLE;
                            wait_d  = WAIT_W'(CS_HIGH_CYCLES - 1);
                        end
                        S_CMD_RST: begin
                            state_d = init_mode ? S_RST_WAIT : S_IDLE;
                            wait_d  = WAIT_W'(RESET_CYCLES - 1);
                        end
                        default: begin
                            poll_d = poll_inc;
                            wait_d = WAIT_W'(CS_HIGH_CYCLES - 1);
                            if (!init_mode)                          state_d = S_IDLE;
                            else if (!rx_sr[0])                      state_d = S_DONE;
                            else if (poll_inc == POLL_W'(MAX_POLLS)) state_d = S_ERROR;
                            else                                     state_d = S_POLL_GAP;
                        end
                    endcase
                end
            end
            default: ;
        endcase

        if (start_frame) begin
            div_d  = '0;
            half_d = '0;
            tx_d   = {start_op, 8'h00};
            rx_d   = '0;
        end
        if (start_frame || in_frame) begin
            cs_n_d = 1'b0;
            sck_d  = half_d[0];
            mosi_d = tx_d[15];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            poll_cnt   <= '0;
            spi_cs_n   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            state      <= state_d;
            wait_cnt   <= wait_d;
            div_cnt    <= div_d;
            half_cnt   <= half_d;
            tx_sr      <= tx_d;
            rx_sr      <= rx_d;
            poll_cnt   <= poll_d;
            spi_cs_n   <= cs_n_d;
            spi_sck    <= sck_d;
            spi_mosi   <= mosi_d;
            init_done  <= (state == S_DONE);
            init_error <= (state == S_ERROR);
        end
    end
endmodule
